// File: rtl/alu_mask_decode.sv
// Recovers the operand size code from a thermometer mask, scanning CHUNK bits per
// cycle from the MSB; also flags all-zero and non-contiguous masks.
module alu_mask_decode #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SIZE_W = 5,
  parameter int unsigned CHUNK  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIZE_W-1:0] out_size,
  output logic              out_zero,
  output logic              out_thermo
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CIDX_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state,      w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,        w_cnt_nxt;
  logic [WIDTH-1:0]  r_shift,      w_shift_nxt;
  logic              r_found,      w_found_nxt;
  logic              r_thermo,     w_thermo_nxt;
  logic [SIZE_W-1:0] r_size,       w_size_nxt;
  logic              r_out_valid,  w_out_valid_nxt;
  logic [SIZE_W-1:0] r_out_size,   w_out_size_nxt;
  logic              r_out_zero,   w_out_zero_nxt;
  logic              r_out_thermo, w_out_thermo_nxt;

  logic [CHUNK-1:0]  w_chunk;
  logic [CIDX_W-1:0] w_hi;
  logic              w_below_ones;
  logic [SIZE_W-1:0] w_chunk_size;

  // Priority encode the current chunk and test the bits under its leading one
  always_comb begin
    w_chunk      = r_shift[WIDTH-1 -: CHUNK];
    w_hi         = '0;
    w_below_ones = 1'b1;
    for (int j = 0; j < CHUNK; j++) begin
      if (w_chunk[j]) w_hi = CIDX_W'(j);
    end
    for (int j = 0; j < CHUNK; j++) begin
      if ((CIDX_W'(j) < w_hi) && !w_chunk[j]) w_below_ones = 1'b0;
    end
    w_chunk_size = SIZE_W'((NCHUNK - 1 - 32'(r_cnt)) * CHUNK + 32'(w_hi));
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_shift_nxt      = r_shift;
    w_found_nxt      = r_found;
    w_thermo_nxt     = r_thermo;
    w_size_nxt       = r_size;
    w_out_valid_nxt  = r_out_valid;
    w_out_size_nxt   = r_out_size;
    w_out_zero_nxt   = r_out_zero;
    w_out_thermo_nxt = r_out_thermo;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_shift_nxt  = in_mask;
          w_found_nxt  = 1'b0;
          w_thermo_nxt = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_SCAN;
        end
      end
      S_SCAN: begin
        w_shift_nxt = r_shift << CHUNK;
        if (!r_found && (w_chunk != '0)) begin
          w_found_nxt  = 1'b1;
          w_size_nxt   = w_chunk_size;
          w_thermo_nxt = r_thermo & w_below_ones;
        end else if (r_found) begin
          w_thermo_nxt = r_thermo & (&w_chunk);
        end
        if (r_cnt == CNT_W'(NCHUNK - 1)) begin
          w_state_nxt      = S_DONE;
          w_out_valid_nxt  = 1'b1;
          w_out_size_nxt   = w_found_nxt ? w_size_nxt : '0;
          w_out_zero_nxt   = !w_found_nxt;
          w_out_thermo_nxt = w_found_nxt & w_thermo_nxt;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_found      <= 1'b0;
      r_thermo     <= 1'b0;
      r_size       <= '0;
      r_out_valid  <= 1'b0;
      r_out_size   <= '0;
      r_out_zero   <= 1'b0;
      r_out_thermo <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_found      <= w_found_nxt;
      r_thermo     <= w_thermo_nxt;
      r_size       <= w_size_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_size   <= w_out_size_nxt;
      r_out_zero   <= w_out_zero_nxt;
      r_out_thermo <= w_out_thermo_nxt;
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = r_out_valid;
  assign out_size   = r_out_size;
  assign out_zero   = r_out_zero;
  assign out_thermo = r_out_thermo;

endmodule
